// File: rtl/platform_pio_pkg.sv
// Shared definitions for the platform PIO blocks: register map and edge-type encodings.
package platform_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Unknown encodings fall back to rising-edge capture.
    function automatic logic [31:0] edge_select(input int edge_type,
                                                input logic [31:0] rise,
                                                input logic [31:0] fall);
        case (edge_type)
            EDGE_FALL: return fall;
            EDGE_ANY:  return rise | fall;
            default:   return rise;
        endcase
    endfunction

endpackage

// File: rtl/platform_pio_debounce.sv
// Single-bit debouncer: q follows d only after d has differed from q for
// DEBOUNCE_CYCLES consecutive samples; bypass loads d straight through.
module platform_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic bypass,
    input  logic d,
    output logic q
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (bypass) begin
            cnt <= '0;
            q   <= d;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            // Final differing sample accepted; counter restarts rather than wrapping.
            cnt <= '0;
            q   <= d;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/platform_pio_input_irq.sv
// Avalon-MM input PIO with synchroniser, edge capture and masked level interrupt.
// Define PLATFORM_PIO_DEBOUNCE_EN to insert a per-bit debouncer ahead of edge detection.
module platform_pio_input_irq
    import platform_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic             priming;
    logic             wr;
    logic             unused_bits;

    assign unused_bits = ^{writedata, DEBOUNCE_CYCLES[0]};

    assign primed  = (prime_cnt == 2'd3);
    assign priming = ~primed;
    assign wr      = chipselect & ~write_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= 2'd0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // While priming, prev is loaded alongside clean so the first armed cycle
    // compares equal values and a level held through reset is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= priming ? s2 : clean;
        end
    end

`ifdef PLATFORM_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        platform_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .bypass(priming),
            .d     (s2[i]),
            .q     (clean[i])
        );
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            clean <= '0;
        end else begin
            clean <= s2;
        end
    end
`endif

    always_comb begin
        rise     = clean & ~prev;
        fall     = ~clean & prev;
        edge_det = '0;
        if (primed) begin
            edge_det = WIDTH'(edge_select(EDGE_TYPE, 32'(rise), 32'(fall)));
        end
        clr_mask = '0;
        if (wr && (address == ADDR_EDGECAP)) begin
            clr_mask = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask  <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // A new edge outranks a simultaneous clear of the same bit.
            edgecap <= (edgecap & ~clr_mask) | edge_det;
            irq     <= |(edgecap & irqmask);
            case (address)
                ADDR_DATA:    readdata <= 32'(clean);
                ADDR_IRQMASK: readdata <= 32'(irqmask);
                ADDR_EDGECAP: readdata <= 32'(edgecap);
                default:      readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_pio_input_irq.sv
// Scoreboard bench for platform_pio_input_irq: rising, falling and any-edge instances share one bus.
module tb_platform_pio_input_irq;
    import platform_pio_pkg::*;

    localparam int W   = 8;
    localparam int DBC = 16;
`ifdef PLATFORM_PIO_DEBOUNCE_EN
    localparam int DLY = 2 + DBC - 1;
`else
    localparam int DLY = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0, rd1, rd2;
    logic          irq0, irq1, irq2;

    always #5 clk = ~clk;

    platform_pio_input_irq #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .DEBOUNCE_CYCLES(DBC)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
    platform_pio_input_irq #(.WIDTH(W), .EDGE_TYPE(EDGE_FALL), .DEBOUNCE_CYCLES(DBC)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
    platform_pio_input_irq #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(DBC)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        int          inst;
        logic [31:0] exp;
        string       tag;
    } rd_exp_t;

    rd_exp_t sb[$];

    function automatic logic [31:0] rd_of(input int inst);
        case (inst)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    always @(negedge clk) begin
        rd_exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq(e.tag, rd_of(e.inst), e.exp);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected readdata of each instance is due on the edge that samples this address.
    task automatic bus_read(input string tag, input logic [1:0] addr,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        address = addr;
        sb.push_back('{due: cyc + 1, inst: 0, exp: e0, tag: {tag, "/rise"}});
        sb.push_back('{due: cyc + 1, inst: 1, exp: e1, tag: {tag, "/fall"}});
        sb.push_back('{due: cyc + 1, inst: 2, exp: e2, tag: {tag, "/any"}});
        step(1);
    endtask

    task automatic check_irq(input string tag, input logic e0, input logic e1, input logic e2);
        @(negedge clk);
        check_eq({tag, "/rise"}, {31'd0, irq0}, {31'd0, e0});
        check_eq({tag, "/fall"}, {31'd0, irq1}, {31'd0, e1});
        check_eq({tag, "/any"},  {31'd0, irq2}, {31'd0, e2});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;

        // Inputs held high through reset must not be captured.
        in_port = 8'hFF;
        reset   = 1'b1;
        step(3);
        check_irq("irq_in_reset", 1'b0, 1'b0, 1'b0);
        check_eq("rd_in_reset/rise", rd0, 32'd0);
        reset = 1'b0;
        step(10);
        bus_read("cap_held", ADDR_EDGECAP, 32'h00, 32'h00, 32'h00);
        bus_read("data_held", ADDR_DATA, 32'hFF, 32'hFF, 32'hFF);
        check_irq("irq_held", 1'b0, 1'b0, 1'b0);

        in_port = 8'h00;
        step(DLY + 4);
        bus_write(ADDR_EDGECAP, 32'hFF);
        bus_read("cap_cleared", ADDR_EDGECAP, 32'h00, 32'h00, 32'h00);

        // Rising edge on bit0 with bit0 unmasked: latency to capture and irq.
        bus_write(ADDR_IRQMASK, 32'h01);
        in_port = 8'h01;
        step(DLY + 1);
        check_irq("irq_before_cap", 1'b0, 1'b0, 1'b0);
        step(1);
        check_irq("irq_at_cap", 1'b0, 1'b0, 1'b0);
        bus_read("cap_b0", ADDR_EDGECAP, 32'h01, 32'h00, 32'h01);
        check_irq("irq_b0", 1'b1, 1'b0, 1'b1);
        bus_write(ADDR_EDGECAP, 32'h01);
        check_irq("irq_clr_n1", 1'b1, 1'b0, 1'b1);
        step(1);
        check_irq("irq_clr_n2", 1'b0, 1'b0, 1'b0);

        // Bit3 up then down with the mask off; enabling the mask raises irq.
        bus_write(ADDR_IRQMASK, 32'h00);
        in_port = 8'h09;
        step(DLY + 2);
        bus_read("cap_b3_up", ADDR_EDGECAP, 32'h08, 32'h00, 32'h08);
        bus_write(ADDR_EDGECAP, 32'h08);
        in_port = 8'h01;
        step(DLY + 2);
        bus_read("cap_b3_down", ADDR_EDGECAP, 32'h00, 32'h08, 32'h08);
        check_irq("irq_masked", 1'b0, 1'b0, 1'b0);
        bus_write(ADDR_IRQMASK, 32'h08);
        check_irq("irq_mask_n1", 1'b0, 1'b0, 1'b0);
        step(1);
        check_irq("irq_mask_n2", 1'b0, 1'b1, 1'b1);
        bus_read("mask_rd", ADDR_IRQMASK, 32'h08, 32'h08, 32'h08);

        // Clear of bit5 lands on the same edge that captures bit5.
        bus_write(ADDR_EDGECAP, 32'hFF);
        in_port = 8'h21;
        step(DLY + 1);
        bus_write(ADDR_EDGECAP, 32'h20);
        bus_read("cap_set_wins", ADDR_EDGECAP, 32'h20, 32'h00, 32'h20);

        // Read mux, ignored writes, upper writedata bits.
        bus_write(ADDR_DATA, 32'hFF);
        bus_write(ADDR_RSVD, 32'hFF);
        bus_write(ADDR_IRQMASK, 32'hFFFF_FF24);
        address = ADDR_IRQMASK;
        writedata = 32'hFF;
        write_n = 1'b0;
        step(1);
        write_n = 1'b1;
        bus_read("mask_rd2", ADDR_IRQMASK, 32'h24, 32'h24, 32'h24);
        bus_read("data_rd", ADDR_DATA, 32'h21, 32'h21, 32'h21);
        bus_read("rsvd_rd", ADDR_RSVD, 32'h00, 32'h00, 32'h00);
        bus_read("cap_kept", ADDR_EDGECAP, 32'h20, 32'h00, 32'h20);
        check_irq("irq_mask24", 1'b1, 1'b0, 1'b1);

        // Reset with captures pending and irq high.
        bus_write(ADDR_IRQMASK, 32'hFF);
        in_port = 8'h00;
        step(DLY + 4);
        bus_write(ADDR_EDGECAP, 32'hFF);
        in_port = 8'h0F;
        step(DLY + 4);
        bus_read("cap_0f", ADDR_EDGECAP, 32'h0F, 32'h00, 32'h0F);
        check_irq("irq_pre_reset", 1'b1, 1'b0, 1'b1);
        reset   = 1'b1;
        in_port = 8'h00;
        step(1);
        check_irq("irq_reset", 1'b0, 1'b0, 1'b0);
        check_eq("rd_reset/rise", rd0, 32'd0);
        check_eq("rd_reset/any", rd2, 32'd0);
        step(2);
        reset = 1'b0;
        step(10);
        bus_read("data_post", ADDR_DATA, 32'h00, 32'h00, 32'h00);
        bus_read("mask_post", ADDR_IRQMASK, 32'h00, 32'h00, 32'h00);
        bus_read("cap_post", ADDR_EDGECAP, 32'h00, 32'h00, 32'h00);
        check_irq("irq_post", 1'b0, 1'b0, 1'b0);

`ifdef PLATFORM_PIO_DEBOUNCE_EN
        // A 10-cycle glitch never reaches clean.
        in_port = 8'h04;
        for (int j = 0; j < 30; j++) begin
            if (j == 10) in_port = 8'h00;
            bus_read("glitch_data", ADDR_DATA, 32'h00, 32'h00, 32'h00);
        end
        step(DLY);
        bus_read("glitch_cap", ADDR_EDGECAP, 32'h00, 32'h00, 32'h00);

        // A 20-cycle pulse passes: clean high for reads j=18..37.
        in_port = 8'h04;
        for (int j = 0; j < 45; j++) begin
            if (j == 20) in_port = 8'h00;
            exp = (j >= 18 && j <= 37) ? 32'h04 : 32'h00;
            bus_read("pulse_data", ADDR_DATA, exp, exp, exp);
        end
        step(4);
        bus_read("pulse_cap", ADDR_EDGECAP, 32'h04, 32'h04, 32'h04);
`endif

        for (int k = 0; k < 10 && sb.size() > 0; k++) step(1);
        if (sb.size() > 0) check_eq("sb_drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
